hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
- Pipeline hazard scheduler for the 5-stage MIPS core. Decides each cycle whether the D-stage instruction may advance.
- Drives `stop` on the next-PC unit (PC held at pc4-4), the F/D register enable, and the D/E bubble insert.
- Keeps its own shadow scoreboard of E/M-stage destinations using Tuse/Tnew timing.
- Sequences the multi-cycle mult/div unit with a busy counter.

Parameters:
- MULT_CYC, 5, E-stage busy cycles after a mult/multu starts.
- DIV_CYC, 10, E-stage busy cycles after a div/divu starts.
- CNT_W, 4, busy counter width; must hold max(MULT_CYC, DIV_CYC).

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
- d_rs  in  5  D-stage rs register address.
- d_rt  in  5  D-stage rt register address.
- d_tuse_rs  in  2  cycles until rs is needed (0 = D, 1 = E, 2 = M, 3 = unused).
- d_tuse_rt  in  2  same encoding for rt.
- d_wa  in  5  D-stage destination register; 0 = none.
- d_tnew  in  2  cycles after entering E until the result is forwardable.
- d_md_start  in  1  D instruction is mult/multu/div/divu.
- d_md_is_div  in  1  qualifies d_md_start: 1 = div, 0 = mult.
- d_md_use  in  1  D instruction is mfhi/mflo/mthi/mtlo/mult/div.
- stop  out  1  to the next-PC unit: hold PC this cycle.
- fd_en  out  1  F/D pipeline register enable; equals ~stop.
- de_clr  out  1  D/E register clear (insert bubble); equals stop.
- md_busy  out  1  mult/div unit busy.
- md_cnt  out  CNT_W  remaining busy cycles.

Behaviour:
- Internal state:
  - e_wa/e_tnew: shadow of the E-stage destination.
  - m_wa/m_tnew: shadow of the M-stage destination.
  - md_cnt: busy counter.
  - e_md_pend: a mult/div sits in E and has not yet loaded md_cnt.
- Reset (reset==0 at a clk edge): all state cleared to 0. Outputs during and after reset: stop=0, fd_en=1, de_clr=0, md_busy=0, md_cnt=0.
- stall (combinational, same cycle as the inputs), asserted if any of:
  - rs hazard: d_rs!=0 and d_rs==e_wa and d_tuse_rs<e_tnew.
  - rs hazard: d_rs!=0 and d_rs==m_wa and d_tuse_rs<m_tnew.
  - rt hazard: the same two checks for d_rt/d_tuse_rt.
  - md hazard: d_md_use and (md_busy or e_md_pend).
- Outputs are driven by stall: stop=stall, fd_en=~stall, de_clr=stall.
- Scoreboard update, each clk edge out of reset:
  - Stage M receives: m_wa<=e_wa; m_tnew<=sat(e_tnew-1), where sat floors at 0.
  - Stage E, not stalled: e_wa<=d_wa; e_tnew<=d_tnew; e_md_pend<=d_md_start.
  - Stage E, stalled (bubble): e_wa<=0; e_tnew<=0; e_md_pend<=0.
  - The W stage is not tracked; the register file write-through covers it.
- Mult/div counter, per clk edge. Priority: load beats decrement.
  - If e_md_pend: md_cnt<=(latched is_div ? DIV_CYC : MULT_CYC). is_div is captured with e_md_pend.
  - Else if md_cnt!=0: md_cnt<=md_cnt-1.
  - md_busy = (md_cnt!=0).
  - md_cnt never wraps below 0.
- Simultaneous hazards: a single stall covers all causes. There is no priority between them.
- Reset mid-busy: md_cnt is cleared immediately and the scoreboard is flushed. The cycle after reset deasserts, stall=0.
- Latency: stall is 0-cycle combinational. Scoreboard and counter effects appear one cycle after the edge.

Optional Feature:
- STALL_STAT_EN, when defined:
  - Adds output stall_cnt [31:0]. It increments on each clk edge where stall==1 and reset==1, wraps at 2^32, and is cleared by reset.
  - Adds output md_stall_cnt [31:0], counting only cycles where the md hazard term is true.
- When undefined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Load-use:
  - Cycle N: D=lw $8 (d_wa=8, d_tnew=2). Cycle N+1: D=addu (d_rs=8, d_tuse_rs=1).
  - Required: stop=1 at N+1, then 0 at N+2.
  - A bubble reaches E: e_wa=0 at N+2.
- Branch in D: beq with d_rs=9, d_tuse_rs=0, while E holds addu $9 (e_tnew=1) → stop=1 for exactly 1 cycle.
- $0 never stalls: d_rs=0 while E has e_wa=0 with e_tnew=2 → stop=0.
- Mult/div sequencing:
  - div enters E (d_md_start=1, d_md_is_div=1), then D=mflo.
  - Required: stop=1 for 11 cycles (1 pending + 10 busy), md_cnt counts 10..1, then 0 with stop=0.
  - Repeat with mult: 6 stall cycles.
- Reset mid-busy: assert reset=0 for one cycle while md_cnt=7 → md_cnt=0, md_busy=0, stop=0 on the following cycle.
- With STALL_STAT_EN, after the div scenario: stall_cnt=11 and md_stall_cnt=11.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hazard_stall_ctrl: D-stage stall decision for the 5-stage MIPS core.       |
// | It keeps a shadow scoreboard of the E and M stages and a mult/div busy     |
// | counter. Defining STALL_STAT_EN adds the stall_cnt and md_stall_cnt        |
// | counters.                                                                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module hazard_stall_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       d_rs,
  input  logic [4:0]       d_rt,
  input  logic [1:0]       d_tuse_rs,
  input  logic [1:0]       d_tuse_rt,
  input  logic [4:0]       d_wa,
  input  logic [1:0]       d_tnew,
  input  logic             d_md_start,
  input  logic             d_md_is_div,
  input  logic             d_md_use,
  output logic             stop,
  output logic             fd_en,
  output logic             de_clr,
  output logic             md_busy,
  output logic [CNT_W-1:0] md_cnt
`ifdef STALL_STAT_EN
  ,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      md_stall_cnt
`endif
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYC);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYC);

  logic [4:0] e_wa;
  logic [1:0] e_tnew;
  logic [4:0] m_wa;
  logic [1:0] m_tnew;
  logic       e_md_pend;
  logic       e_md_div;

  logic       rs_haz;
  logic       rt_haz;
  logic       md_haz;
  logic       stall;

  // Register 0 is hard-wired, so it can never carry a pending result.
  always_comb begin
    rs_haz = (d_rs != 5'd0) &&
             (((d_rs == e_wa) && (d_tuse_rs < e_tnew)) ||
              ((d_rs == m_wa) && (d_tuse_rs < m_tnew)));
    rt_haz = (d_rt != 5'd0) &&
             (((d_rt == e_wa) && (d_tuse_rt < e_tnew)) ||
              ((d_rt == m_wa) && (d_tuse_rt < m_tnew)));
    md_haz = reset && d_md_use && (md_busy || e_md_pend);
    stall  = reset && (rs_haz || rt_haz || md_haz);
  end

  assign stop    = stall;
  assign fd_en   = ~stall;
  assign de_clr  = stall;
  assign md_busy = (md_cnt != '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      e_wa      <= 5'd0;
      e_tnew    <= 2'd0;
      m_wa      <= 5'd0;
      m_tnew    <= 2'd0;
      e_md_pend <= 1'b0;
      e_md_div  <= 1'b0;
      md_cnt    <= '0;
    end else begin
      m_wa   <= e_wa;
      m_tnew <= (e_tnew == 2'd0) ? 2'd0 : e_tnew - 2'd1;
      if (stall) begin
        e_wa      <= 5'd0;
        e_tnew    <= 2'd0;
        e_md_pend <= 1'b0;
        e_md_div  <= 1'b0;
      end else begin
        e_wa      <= d_wa;
        e_tnew    <= d_tnew;
        e_md_pend <= d_md_start;
        e_md_div  <= d_md_is_div;
      end
      // A mult/div reaching E reloads the counter even if it is still running.
      if (e_md_pend) begin
        md_cnt <= e_md_div ? DIV_LOAD : MULT_LOAD;
      end else if (md_cnt != '0) begin
        md_cnt <= md_cnt - 1'b1;
      end
    end
  end

`ifdef STALL_STAT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt    <= 32'd0;
      md_stall_cnt <= 32'd0;
    end else begin
      if (stall) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (md_haz) begin
        md_stall_cnt <= md_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_hazard_stall_ctrl: directed stimulus with a timeline-based reference    |
// | model of producer readiness and mult/div occupancy.                        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_hazard_stall_ctrl;

  logic       clk;
  logic       reset;
  logic [4:0] d_rs, d_rt, d_wa;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       d_md_start, d_md_is_div, d_md_use;
  logic       stop, fd_en, de_clr, md_busy;
  logic [3:0] md_cnt;
`ifdef STALL_STAT_EN
  logic [31:0] stall_cnt, md_stall_cnt;
`endif

  hazard_stall_ctrl #(.MULT_CYC(5), .DIV_CYC(10), .CNT_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .d_rs        (d_rs),
    .d_rt        (d_rt),
    .d_tuse_rs   (d_tuse_rs),
    .d_tuse_rt   (d_tuse_rt),
    .d_wa        (d_wa),
    .d_tnew      (d_tnew),
    .d_md_start  (d_md_start),
    .d_md_is_div (d_md_is_div),
    .d_md_use    (d_md_use),
    .stop        (stop),
    .fd_en       (fd_en),
    .de_clr      (de_clr),
    .md_busy     (md_busy),
    .md_cnt      (md_cnt)
`ifdef STALL_STAT_EN
    ,
    .stall_cnt   (stall_cnt),
    .md_stall_cnt(md_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: each accepted D instruction at cycle t is in E at t+1, in M at t+2,
  // and its result is usable from cycle t+1+tnew onward.
  int cyc = 0;
  int last_rst = -1;
  bit iv [0:1023];
  int iwa[0:1023];
  int itn[0:1023];
  bit md_v = 1'b0;
  int md_t = 0;
  int md_n = 0;
  int sc = 0;
  int msc = 0;
  bit e_stall = 1'b0;
  bit e_md = 1'b0;

  function automatic bit reg_haz(input int r, input int tuse);
    bit res = 1'b0;
    if (r != 0) begin
      for (int k = 1; k <= 2; k++) begin
        int t = cyc - k;
        if (t >= 0 && t > last_rst && iv[t] && iwa[t] == r && cyc + tuse < t + 1 + itn[t])
          res = 1'b1;
      end
    end
    return res;
  endfunction

  always @(negedge clk) begin
    bit s, m;
    int ecnt;
    if (cyc >= 1) begin
      m    = reset && d_md_use && md_v && (cyc >= md_t + 1) && (cyc <= md_t + 1 + md_n);
      s    = reset && (reg_haz(int'(d_rs), int'(d_tuse_rs)) || reg_haz(int'(d_rt), int'(d_tuse_rt)) || m);
      ecnt = (md_v && cyc >= md_t + 2 && cyc <= md_t + 1 + md_n) ? (md_t + 2 + md_n - cyc) : 0;
      chk("model_stop", {31'd0, stop}, {31'd0, s});
      chk("model_fd_en", {31'd0, fd_en}, {31'd0, ~s});
      chk("model_de_clr", {31'd0, de_clr}, {31'd0, s});
      chk("model_md_cnt", {28'd0, md_cnt}, ecnt);
      chk("model_md_busy", {31'd0, md_busy}, {31'd0, ecnt != 0});
`ifdef STALL_STAT_EN
      chk("model_stall_cnt", stall_cnt, sc);
      chk("model_md_stall_cnt", md_stall_cnt, msc);
`endif
      e_stall <= s;
      e_md    <= m;
    end
  end

  always @(posedge clk) begin
    if (cyc >= 1023) begin
      $display("FAIL cycle_budget: got %0d, expected below 1023", cyc);
      $fatal(1, "cycle budget exceeded");
    end
    if (!reset) begin
      last_rst <= cyc;
      md_v     <= 1'b0;
      sc       <= 0;
      msc      <= 0;
      iv[cyc]  <= 1'b0;
    end else begin
      iv[cyc]  <= !e_stall;
      iwa[cyc] <= int'(d_wa);
      itn[cyc] <= int'(d_tnew);
      if (!e_stall && d_md_start) begin
        md_v <= 1'b1;
        md_t <= cyc;
        md_n <= d_md_is_div ? 10 : 5;
      end
      if (e_stall) sc  <= sc + 1;
      if (e_md)    msc <= msc + 1;
    end
    cyc <= cyc + 1;
  end

  task automatic drv(input logic [4:0] rs, input logic [1:0] trs, input logic [4:0] rt,
                     input logic [1:0] trt, input logic [4:0] wa, input logic [1:0] tn,
                     input logic ms, input logic mdiv, input logic mu);
    d_rs = rs; d_tuse_rs = trs; d_rt = rt; d_tuse_rt = trt;
    d_wa = wa; d_tnew = tn; d_md_start = ms; d_md_is_div = mdiv; d_md_use = mu;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Runs a mult/div followed by mflo and returns how many cycles mflo stalled.
  task automatic md_seq(input logic is_div, output int n);
    n = 0;
    drv(0, 3, 0, 3, 0, 0, 1, is_div, 1);
    nxt();
    drv(0, 3, 0, 3, 2, 1, 0, 0, 1);
    for (int i = 0; i < 40; i++) begin
      smp();
      if (!stop) break;
      n++;
      if (n == 2) chk(is_div ? "div_first_cnt" : "mult_first_cnt", {28'd0, md_cnt}, is_div ? 10 : 5);
      nxt();
    end
  endtask

  initial begin
    int n;
    reset = 1'b0;
    drv(0, 3, 0, 3, 0, 0, 0, 0, 0);
    nxt();
    nxt();
    reset = 1'b1;
    smp();
    chk("reset_stop", {31'd0, stop}, 0);
    chk("reset_fd_en", {31'd0, fd_en}, 1);
    chk("reset_md_cnt", {28'd0, md_cnt}, 0);

    // load-use: lw $8 then addu using $8 in E
    nxt(); drv(0, 3, 0, 3, 8, 2, 0, 0, 0);
    smp(); chk("lu_pre", {31'd0, stop}, 0);
    nxt(); drv(8, 1, 0, 3, 10, 1, 0, 0, 0);
    smp(); chk("lu_stall", {31'd0, stop}, 1);
    chk("lu_de_clr", {31'd0, de_clr}, 1);
    nxt();
    smp(); chk("lu_release", {31'd0, stop}, 0);
    chk("lu_bubble_e_wa", {27'd0, dut.e_wa}, 0);

    // branch reading $9 in D while addu $9 sits in E
    nxt(); drv(0, 3, 0, 3, 9, 1, 0, 0, 0);
    nxt(); drv(9, 0, 0, 3, 0, 0, 0, 0, 0);
    smp(); chk("br_stall", {31'd0, stop}, 1);
    nxt();
    smp(); chk("br_release", {31'd0, stop}, 0);

    // $0 never stalls
    nxt(); drv(0, 3, 0, 3, 0, 2, 0, 0, 0);
    nxt(); drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    smp(); chk("zero_reg", {31'd0, stop}, 0);

    // rt hazard against the M stage
    nxt(); drv(0, 3, 0, 3, 5, 2, 0, 0, 0);
    nxt(); drv(0, 3, 0, 3, 0, 0, 0, 0, 0);
    nxt(); drv(0, 3, 5, 0, 0, 0, 0, 0, 0);
    smp(); chk("m_rt_stall", {31'd0, stop}, 1);
    nxt();
    smp(); chk("m_rt_release", {31'd0, stop}, 0);

    // fresh reset so statistics start from zero
    nxt(); drv(0, 3, 0, 3, 0, 0, 0, 0, 0);
    reset = 1'b0;
    nxt(); reset = 1'b1;

    md_seq(1'b1, n);
    chk("div_stall_cycles", n, 11);
    chk("div_done_cnt", {28'd0, md_cnt}, 0);
    chk("div_done_busy", {31'd0, md_busy}, 0);
`ifdef STALL_STAT_EN
    chk("div_stall_cnt", stall_cnt, 11);
    chk("div_md_stall_cnt", md_stall_cnt, 11);
`endif
    nxt(); drv(0, 3, 0, 3, 0, 0, 0, 0, 0);
    nxt();

    md_seq(1'b0, n);
    chk("mult_stall_cycles", n, 6);
    chk("mult_done_cnt", {28'd0, md_cnt}, 0);
    nxt(); drv(0, 3, 0, 3, 0, 0, 0, 0, 0);
    nxt();

    // reset while the divider still has 7 cycles to go
    drv(0, 3, 0, 3, 0, 0, 1, 1, 1);
    nxt();
    drv(0, 3, 0, 3, 2, 1, 0, 0, 1);
    for (int i = 0; i < 40; i++) begin
      smp();
      if (md_cnt == 4'd7) break;
      nxt();
    end
    chk("rmb_reach7", {28'd0, md_cnt}, 7);
    #2 reset = 1'b0;
    nxt(); reset = 1'b1;
    smp();
    chk("rmb_md_cnt", {28'd0, md_cnt}, 0);
    chk("rmb_md_busy", {31'd0, md_busy}, 0);
    chk("rmb_stop", {31'd0, stop}, 0);

    nxt(); drv(0, 3, 0, 3, 0, 0, 0, 0, 0);
    repeat (3) nxt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
